// File: rtl/flash_pkg.sv
// Purpose : shared state encodings and default widths for the flash read master.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package flash_pkg;

    localparam int ADDR_W_DEF = 23;
    localparam int DATA_W_DEF = 32;

    // State encodings are plain constants so legacy tools and testbenches that
    // compare raw state values keep working.
    typedef logic [1:0] state_t;

    localparam state_t IDLE       = 2'd0;
    localparam state_t READ       = 2'd1;
    localparam state_t WAIT_VALID = 2'd2;
    localparam state_t DONE       = 2'd3;

endpackage

// File: rtl/read_flash_fsm.sv
// Purpose : single-word Avalon-MM read master for the on-board flash.
// Latency : start edge to finished high is 3 cycles minimum, +1 per stall or extra valid-latency cycle.
// Backpressure: holds read/address stable while wait_request is high, unbounded.
//
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   start             - level request, only looked at in IDLE
//   address_in        - word address, latched when start is accepted
//   wait_request      - slave stall, read not accepted while high
//   data_valid        - slave readdatavalid, only honoured in WAIT_VALID
//   readdata          - slave read data
//   read, address     - Avalon read strobe and address (Moore-decoded / registered)
//   data_out          - last captured word, held between transactions
//   finished          - one-cycle done pulse
module read_flash_fsm
    import flash_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] address_in,
    input  logic              wait_request,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] readdata,
    output logic              read,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    output logic              finished
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = address_in;
                    state_d = READ;
                end
            end
            READ: begin
                if (!wait_request) begin
                    state_d = WAIT_VALID;
                end
            end
            WAIT_VALID: begin
                // data_valid seen in IDLE/READ is never ours; only capture here.
                if (data_valid) begin
                    data_d  = readdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Always return through IDLE so finished is a clean single pulse
                // even when start is held high.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Moore outputs straight off the state register: no combinational paths
    // from the slave inputs to read/finished.
    assign read     = (state_q == READ);
    assign finished = (state_q == DONE);
    assign address  = addr_q;
    assign data_out = data_q;

endmodule

// File: tb/tb_read_flash_fsm.sv
// Purpose : self-checking bench for read_flash_fsm with a finished-driven scoreboard.
// Latency : n/a.
// Backpressure: bench drives wait_request / data_valid patterns directly.
module tb_read_flash_fsm;

    localparam int AW = 23;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] address_in;
    logic          wait_request;
    logic          data_valid;
    logic [DW-1:0] readdata;
    logic          read;
    logic [AW-1:0] address;
    logic [DW-1:0] data_out;
    logic          finished;

    int checks = 0;
    int fails  = 0;
    exp_t exp_q[$];

    read_flash_fsm #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .address_in  (address_in),
        .wait_request(wait_request),
        .data_valid  (data_valid),
        .readdata    (readdata),
        .read        (read),
        .address     (address),
        .data_out    (data_out),
        .finished    (finished)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every finished pulse must match the oldest expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (finished === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_finished", 64'(finished), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data_out", 64'(data_out), 64'(e.data));
                    chk("sb_address",  64'(address),  64'(e.addr));
                end
            end
        end
    end

    // Directed vectors: wait-request cycles, extra valid latency, and hand-computed
    // number of read cycles and the cycle (after the start edge) finished rises.
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            w;
        int            d;
        int            exp_reads;
        int            exp_fin;
    } vec_t;

    vec_t vecs[4] = '{
        '{23'h000010, 32'hDEADBEEF, 0, 0, 1, 3},
        '{23'h2AAAAA, 32'hCAFEF00D, 5, 0, 6, 8},
        '{23'h000123, 32'h12345678, 0, 4, 1, 7},
        '{23'h7FFFFF, 32'hFFFFFFFF, 2, 1, 3, 6}
    };

    task automatic run_txn(input vec_t v);
        int reads;
        int fin_k;
        int fin_cnt;
        reads   = 0;
        fin_k   = 0;
        fin_cnt = 0;
        @(posedge clk); #1;
        start        = 1'b1;
        address_in   = v.addr;
        wait_request = 1'b1;
        data_valid   = 1'b1;          // spurious valid in IDLE must be ignored
        readdata     = 32'h0BAD0BAD;
        exp_q.push_back('{addr: v.addr, data: v.data});
        for (int k = 1; k <= v.exp_fin + 2; k++) begin
            @(posedge clk); #1;
            start        = 1'b0;        // deasserting mid-transaction has no effect
            address_in   = ~v.addr;     // address output must not follow this
            wait_request = (k <= v.w);
            data_valid   = (k <= v.w + 1) || (k == v.w + 2 + v.d);
            readdata     = (k == v.w + 2 + v.d) ? v.data : 32'h0BAD0BAD;
            @(negedge clk);
            if (read) begin
                reads++;
                if (reads == 1 || k == v.w + 1) chk("addr_stable", 64'(address), 64'(v.addr));
            end
            if (finished) begin
                fin_cnt++;
                if (fin_k == 0) fin_k = k;
            end
        end
        data_valid = 1'b0;
        chk("read_cycles",   64'(reads),   64'(v.exp_reads));
        chk("finished_cyc",  64'(fin_k),   64'(v.exp_fin));
        chk("finished_cnt",  64'(fin_cnt), 64'd1);
        chk("data_hold",     64'(data_out), 64'(v.data));
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b1;
        address_in   = 23'h1ABCDE;
        wait_request = 1'b0;
        data_valid   = 1'b1;
        readdata     = 32'hA5A5A5A5;

        // Reset held two cycles with start high
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_read",     64'(read),     64'd0);
        chk("rst_finished", 64'(finished), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_address",  64'(address),  64'd0);
        @(posedge clk); #1;
        reset      = 1'b0;
        start      = 1'b0;
        data_valid = 1'b0;
        @(negedge clk);
        chk("idle_after_rst_read", 64'(read), 64'd0);

        // Directed transactions
        foreach (vecs[i]) run_txn(vecs[i]);

        // Held start re-triggers with a 4-cycle period
        @(posedge clk); #1;
        start        = 1'b1;
        address_in   = 23'h000040;
        wait_request = 1'b0;
        data_valid   = 1'b1;
        readdata     = 32'h600DF00D;
        exp_q.push_back('{addr: 23'h000040, data: 32'h600DF00D});
        exp_q.push_back('{addr: 23'h000040, data: 32'h600DF00D});
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 5) start = 1'b0;
            @(negedge clk);
            chk($sformatf("held_read_k%0d", k),     64'(read),     64'((k == 1) || (k == 5)));
            chk($sformatf("held_finished_k%0d", k), 64'(finished), 64'((k == 3) || (k == 7)));
        end
        data_valid = 1'b0;

        // Slave busy, no start: FSM must stay idle
        wait_request = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("busy_read",     64'(read),     64'd0);
            chk("busy_finished", 64'(finished), 64'd0);
        end

        // Reset in the middle of a stalled read
        @(posedge clk); #1;
        start      = 1'b1;
        address_in = 23'h000055;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("pre_rst_read", 64'(read), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_read",     64'(read),     64'd0);
        chk("midrst_address",  64'(address),  64'd0);
        chk("midrst_data_out", 64'(data_out), 64'd0);
        wait_request = 1'b0;
        data_valid   = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_read", 64'(read), 64'd0);
        end
        data_valid = 1'b0;

        // Fresh transaction after the abandoned one
        run_txn('{23'h000321, 32'h87654321, 1, 0, 2, 4});

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/read_flash_fsm.md
Name: read_flash_fsm

Overview:
Single-word read master for the on-board flash's Avalon-MM slave port. On `start`, the block:
- latches an address,
- issues one read, honouring `wait_request`,
- waits for `data_valid`,
- captures the word and pulses `finished` for one cycle.

It sits between the audio-sample address generator and the flash controller IP.

Parameters:
- ADDR_W, 23, flash word-address width.
- DATA_W, 32, flash read-data width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; returns FSM to IDLE.
- start  input  1  level request; sampled only in IDLE.
- address_in  input  ADDR_W  word address, latched when a start is accepted.
- wait_request  input  1  slave stall; read not accepted while high.
- data_valid  input  1  slave readdatavalid; readdata valid this cycle.
- readdata  input  DATA_W  slave read data.
- read  output  1  Avalon read strobe.
- address  output  ADDR_W  Avalon address, held stable for the whole transaction.
- data_out  output  DATA_W  last captured word.
- finished  output  1  one-cycle done pulse.

Behaviour:
- One clock (`clk`); reset synchronous, active-high. Reset values: state=IDLE, read=0, finished=0, address=0, data_out=0.
- Moore FSM, outputs decoded from the state register (glitch-free): `read`=1 only in READ; `finished`=1 only in DONE.
- IDLE: if start=1 at an edge, latch address_in into `address` and go to READ; else stay.
- READ: read=1. If wait_request=0 at an edge, the read is accepted; go to WAIT_VALID. Else hold READ with address and read stable, with no limit on stall cycles.
- WAIT_VALID: read=0. If data_valid=1 at an edge, capture readdata into data_out and go to DONE; else stay.
  - data_valid arriving while in IDLE or READ is ignored; the slave's latency is ≥1 cycle after acceptance.
- DONE: finished=1 for exactly one cycle, then unconditionally go to IDLE.
  - DONE is never skipped, even if start stays high.
- A held `start` therefore re-triggers: DONE→IDLE→READ. The minimum period is 4 cycles with zero wait and one-cycle valid latency.
- Latency from start edge to finished high is 3 cycles minimum (IDLE→READ→WAIT_VALID→DONE). Each wait_request-high cycle in READ adds 1; each extra cycle of data_valid latency adds 1.
- `address` changes only on start acceptance in IDLE. `data_out` changes only on a capture and holds between transactions.
- start deasserting mid-transaction has no effect; the transaction completes.
- reset in any state:
  - forces IDLE on the next edge;
  - the in-flight read is abandoned with read=0 immediately after that edge;
  - data_out and address clear to 0.
- Unreachable state encodings go to IDLE.

Decomposition:
- Shared package `flash_pkg`: state enum (IDLE, READ, WAIT_VALID, DONE), ADDR_W/DATA_W defaults.
- No sub-module needed; single FSM with state register, address register and data register.

Test Plan:
- Reset: reset=1 for 2 cycles with start=1 → read=0, finished=0, data_out=0, address=0; IDLE after release.
- Zero-wait read: start=1, wait_request=0, data_valid=1, address_in=0x000010, readdata=0xDEADBEEF →
  - read high for exactly 1 cycle (cycle 1);
  - finished high in cycle 3;
  - data_out=0xDEADBEEF, address=0x000010.
  - With start held, read re-asserts every 4 cycles.
- Stall: start=1, wait_request=1 for 5 cycles then 0 → read stays high for 6 cycles with address constant; finished 2 cycles after wait_request falls.
- Slave busy, no valid: start=0, wait_request=1, data_valid=0 for 10 cycles → read=0, finished=0 throughout; FSM stays IDLE.
- Late valid: start=1, wait_request=0, data_valid=0 for 4 cycles after acceptance then 1 with readdata=0x12345678 → read 1 cycle; finished 1 cycle after valid; data_out=0x12345678; spurious data_valid before acceptance not captured.
- Reset mid-transaction: assert reset while in READ with wait_request=1 → read=0 the next cycle; no finished pulse; the next start begins a fresh transaction.
